// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared modes, default widths and board timing constants for the timebase
package clk_gen_pkg;
  typedef enum logic {MODE_SQUARE = 1'b0, MODE_PULSE = 1'b1} mode_e;
  localparam int DEF_CNT_W = 28;
  localparam int unsigned MASTER_HZ = 100_000_000;
  localparam int unsigned FAST_DIV = 100000;
  localparam int unsigned BLINK_DIV = 40000000;
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divider slice producing a wrap tick and square/pulse output
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [CNT_W-1:0] INIT_DIV = '0
) (
  input  logic             master_clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] ld_div_i,
  input  mode_e            ld_mode_i,
  output logic             tick_o,
  output logic             out_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d;
  mode_e mode_q, mode_d;
  logic lvl_q, lvl_d, tick_q, tick_d;
  logic run, wrap, restart;
  assign run = en_i && div_q != '0;
  assign wrap = run && cnt_q == div_q - CNT_W'(1);
  assign restart = load_i || clr_i;
  always_comb begin
    cnt_d = restart ? '0 : run ? (wrap ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    div_d = load_i ? ld_div_i : div_q;
    mode_d = load_i ? ld_mode_i : mode_q;
    lvl_d = restart ? 1'b0 : lvl_q ^ wrap;
    tick_d = !restart && wrap;
  end
  always_ff @(posedge master_clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= INIT_DIV;
      mode_q <= MODE_SQUARE;
      lvl_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      mode_q <= mode_d;
      lvl_q <= lvl_d;
      tick_q <= tick_d;
    end
  end
  assign tick_o = tick_q;
  assign out_o = mode_q == MODE_PULSE ? tick_q : lvl_q;
endmodule

// File: rtl/clock_enable_bank.sv
// clock_enable_bank: runtime-programmable multi-channel tick generator with pixel enable
module clock_enable_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(BLINK_DIV), CNT_W'(BLINK_DIV), CNT_W'(FAST_DIV), CNT_W'(FAST_DIV)},
  parameter int PIX_DIV = 4,
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic              master_clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic [NUM_CH-1:0] sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] out,
  output logic              pix_tick
);
  localparam int PIX_W = $clog2(PIX_DIV);
  logic cfg_ready_q, pix_tick_q, accept;
  logic [PIX_W-1:0] pix_cnt_q;
  assign accept = cfg_valid && cfg_ready_q;
  // ready drops for exactly one cycle after each accept
  always_ff @(posedge master_clk) begin
    if (rst) begin
      cfg_ready_q <= 1'b1;
      pix_cnt_q <= '0;
      pix_tick_q <= 1'b0;
    end else begin
      cfg_ready_q <= !accept;
      pix_cnt_q <= pix_cnt_q + PIX_W'(1);
      pix_tick_q <= pix_cnt_q == PIX_W'(PIX_DIV - 1);
    end
  end
  assign cfg_ready = cfg_ready_q;
  assign pix_tick = pix_tick_q;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_channel #(
      .CNT_W(CNT_W),
      .INIT_DIV(DIV_INIT[g*CNT_W +: CNT_W])
    ) u_ch (
      .master_clk(master_clk),
      .rst(rst),
      .en_i(en_in),
      .clr_i(sync_clr[g]),
      .load_i(accept && cfg_ch == CH_W'(g)),
      .ld_div_i(cfg_div),
      .ld_mode_i(mode_e'(cfg_mode)),
      .tick_o(tick[g]),
      .out_o(out[g])
    );
  end
endmodule
